// File: rtl/tt_example_pkg.sv
// Shared constants for the tt_um_example input conditioner: uo_out bit map and counter width.
package tt_example_pkg;

    localparam int unsigned Q_BIT    = 0;
    localparam int unsigned RISE_BIT = 1;
    localparam int unsigned FALL_BIT = 2;
    localparam int unsigned TOG_BIT  = 3;
    localparam int unsigned CNT_LSB  = 4;
    localparam int unsigned CNT_W    = 4;

endpackage : tt_example_pkg

// File: rtl/tt_example_edge_det.sv
// Registers the monitored input and flags its rising/falling edges.
// Optional SYNC_STAGE_EN adds a 2-flop synchroniser ahead of the q register.
module tt_example_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic s,
    output logic q,
    output logic rise_c,
    output logic fall_c
);

    logic q_q, q_d;
    logic prev_q, prev_d;
    logic s_eff;

`ifdef SYNC_STAGE_EN
    logic [1:0] sync_q, sync_d;

    // Two-stage synchroniser; stalls together with the rest of the state.
    always_comb begin
        sync_d = sync_q;
        if (ena) begin
            sync_d = {sync_q[0], s};
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign s_eff = sync_q[1];
`else
    assign s_eff = s;
`endif

    always_comb begin
        q_d    = q_q;
        prev_d = prev_q;
        if (ena) begin
            q_d    = s_eff;
            prev_d = q_q;
        end
    end

    // rst_n is the harness name; reset is active-high and synchronous.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            q_q    <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            prev_q <= prev_d;
        end
    end

    assign q      = q_q;
    assign rise_c = q_q & ~prev_q;
    assign fall_c = ~q_q & prev_q;

endmodule : tt_example_edge_det

// File: rtl/tt_um_example.sv
// TinyTapeout slot: single-bit conditioner with edge pulses, toggle flag and rising-edge counter.
// Define SYNC_STAGE_EN to insert a 2-flop input synchroniser (2 extra edges of latency).
module tt_um_example #(
    parameter int unsigned IN_BIT = 0,
    parameter int unsigned CNT_W  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    import tt_example_pkg::*;

    logic             q;
    logic             rise_c;
    logic             fall_c;
    logic             tog_q, tog_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             unused_inputs;

    tt_example_edge_det u_edge_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .s      (ui_in[IN_BIT]),
        .q      (q),
        .rise_c (rise_c),
        .fall_c (fall_c)
    );

    // Toggle and count once per registered rising edge; counter wraps silently.
    always_comb begin
        tog_d = tog_q;
        cnt_d = cnt_q;
        if (ena && rise_c) begin
            tog_d = ~tog_q;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            tog_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            tog_q <= tog_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        uo_out                     = '0;
        uo_out[Q_BIT]              = q;
        uo_out[RISE_BIT]           = rise_c;
        uo_out[FALL_BIT]           = fall_c;
        uo_out[TOG_BIT]            = tog_q;
        uo_out[CNT_LSB +: CNT_W]   = cnt_q;
    end

    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    assign unused_inputs = ^{uio_in, ui_in};

endmodule : tt_um_example

// File: tb/tb_tt_um_example.sv
// Directed bench for tt_um_example: vector table plus hand-written multi-cycle sequences.
module tb_tt_um_example;

`ifdef SYNC_STAGE_EN
    localparam int unsigned LAT = 3;
`else
    localparam int unsigned LAT = 1;
`endif

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int total;
    int bad;

    typedef struct {
        logic       rst;
        logic       en;
        logic       din;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[14];

    tt_um_example dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial begin
        clk = 1'b0;
        forever #2 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Drive at the falling edge, let one rising edge pass, settle 1 ns after it.
    task automatic step(input logic rst, input logic en, input logic din);
        @(negedge clk);
        rst_n  = rst;
        ena    = en;
        ui_in  = {7'b1010101, din};
        uio_in = 8'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        check("reset_uo_out", uo_out, 8'h00);
        check("reset_uio_oe", uio_oe, 8'h00);
        check("reset_uio_out", uio_out, 8'h00);
    endtask

    initial begin
        int rises;
        logic [7:0] e;

        total  = 0;
        bad    = 0;
        rst_n  = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'hFF;
        uio_in = 8'h00;

        vecs[0]  = '{1'b1, 1'b1, 1'b1, 8'h00};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 8'h00};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 8'h03};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 8'h19};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h1C};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h18};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h18};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'h18};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 8'h1B};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 8'h21};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h21};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 8'h24};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 8'h00};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 8'h00};

        do_reset();

`ifndef SYNC_STAGE_EN
        for (int i = 0; i < 14; i++) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].din);
            check($sformatf("vec%0d_uo_out", i), uo_out, vecs[i].exp);
            check($sformatf("vec%0d_uio_oe", i), uio_oe, 8'h00);
        end
`endif

        // Single one-period pulse: q/rise, then fall with tog=1 cnt=1, then idle.
        do_reset();
        step(1'b0, 1'b1, 1'b0);
        check("pulse_idle", uo_out, 8'h00);
        step(1'b0, 1'b1, 1'b1);
        for (int i = 1; i <= int'(LAT) + 2; i++) begin
            if (i < int'(LAT))             e = 8'h00;
            else if (i == int'(LAT))       e = 8'h03;
            else if (i == int'(LAT) + 1)   e = 8'h1C;
            else                           e = 8'h18;
            check($sformatf("pulse_edge%0d", i), uo_out, e);
            if (i < int'(LAT) + 2) step(1'b0, 1'b1, 1'b0);
        end

        // Glitch that never meets a sampling edge is ignored.
        @(negedge clk);
        ui_in = 8'h01;
        #1;
        ui_in = 8'h00;
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(LAT) + 1; i++) step(1'b0, 1'b1, 1'b0);
        check("glitch_ignored", uo_out, 8'h18);

        // Held high for 10 edges: one rise pulse, one count.
        do_reset();
        rises = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b1);
            if (uo_out[1]) rises++;
        end
        check("held_rises", 8'(rises), 8'd1);
        check("held_uo_out", uo_out, 8'h19);

        // 17 pulses, 2 high / 2 low: counter wraps to 1, toggle ends at 1.
        do_reset();
        for (int p = 0; p < 17; p++) begin
            step(1'b0, 1'b1, 1'b1);
            step(1'b0, 1'b1, 1'b1);
            step(1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b1, 1'b0);
        end
        for (int i = 0; i < int'(LAT) + 2; i++) step(1'b0, 1'b1, 1'b0);
        check("wrap_uo_out", uo_out, 8'h18);

        // Input rises while disabled; nothing moves until ena returns.
        do_reset();
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check("ena_off_hold", uo_out, 8'h00);
        for (int i = 1; i <= int'(LAT); i++) begin
            step(1'b0, 1'b1, 1'b1);
            check($sformatf("ena_on_edge%0d", i), uo_out, (i == int'(LAT)) ? 8'h03 : 8'h00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_tt_um_example
